hex_decoder_capture: RTL and testbench

HEX_DECODER_CAPTURE -- requirements
Module: hex_decoder_capture

---
 rtl/hex_decoder_capture.sv | 178 +++++++++++++++++
 tb/tb_hex_decoder_capture.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hex_decoder_capture.sv
// hex_decoder_capture: debounces an active-low seven-segment pattern, decodes
// it to a hex nibble and assembles NUM_DIGITS accepted nibbles into a word.
// The first accepted digit ends up in the most significant nibble.
module hex_decoder_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [0:6]              HEX,
    input  logic                    hex_valid,
    output logic [4*NUM_DIGITS-1:0] data,
    output logic                    data_valid,
    output logic [3:0]              digit,
    output logic                    error,
    output logic                    busy
);

    localparam int WW = 4 * NUM_DIGITS;
    localparam int IW = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, WAIT_REL} state_t;
    typedef enum logic [1:0] {K_DIGIT, K_BLANK, K_ILLEGAL} kind_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [0:6]      ref_q, ref_d;
    logic [WW-1:0]   word_q, word_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [WW-1:0]   data_q, data_d;
    logic [3:0]      digit_q, digit_d;
    logic            data_valid_q, data_valid_d;
    logic            error_q, error_d;

    kind_t           dec_kind;
    logic [3:0]      dec_nib;
    logic            accept;
    logic [3:0]      cnt_inc;
    logic [IW-1:0]   idx_inc;
    logic [WW-1:0]   word_shift;

    // Segment pattern (a..g, active-low) to nibble / blank / illegal.
    always_comb begin
        dec_kind = K_DIGIT;
        dec_nib  = 4'h0;
        case (HEX)
            7'b0000001: dec_nib = 4'h0;
            7'b1001111: dec_nib = 4'h1;
            7'b0010010: dec_nib = 4'h2;
            7'b0000110: dec_nib = 4'h3;
            7'b1001100: dec_nib = 4'h4;
            7'b0100100: dec_nib = 4'h5;
            7'b0100000: dec_nib = 4'h6;
            7'b0001111: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0001100: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b1100000: dec_nib = 4'hB;
            7'b0110001: dec_nib = 4'hC;
            7'b1000010: dec_nib = 4'hD;
            7'b0110000: dec_nib = 4'hE;
            7'b0111000: dec_nib = 4'hF;
            7'b1111111: dec_kind = K_BLANK;
            default:    dec_kind = K_ILLEGAL;
        endcase
    end

    // Debounce FSM plus word assembly; everything registered below.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ref_d        = ref_q;
        word_d       = word_q;
        idx_d        = idx_q;
        data_d       = data_q;
        digit_d      = digit_q;
        data_valid_d = 1'b0;
        error_d      = 1'b0;
        accept       = 1'b0;
        cnt_inc      = cnt_q + 4'd1;
        idx_inc      = idx_q + IW'(1);
        // New nibble enters at the LSB end; older digits move toward the MSB.
        word_shift      = word_q << 4;
        word_shift[3:0] = dec_nib;

        case (state_q)
            IDLE: begin
                if (hex_valid) begin
                    ref_d   = HEX;
                    cnt_d   = 4'd1;
                    state_d = SETTLE;
                    // A single required sample means the entry sample is enough.
                    if (STABLE_CYCLES == 1) begin
                        accept  = 1'b1;
                        state_d = WAIT_REL;
                    end
                end
            end
            SETTLE: begin
                if (!hex_valid) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (HEX != ref_q) begin
                    ref_d = HEX;
                    cnt_d = 4'd1;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 4'(STABLE_CYCLES)) begin
                        accept  = 1'b1;
                        state_d = WAIT_REL;
                    end
                end
            end
            WAIT_REL: begin
                if (!hex_valid) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            case (dec_kind)
                K_DIGIT: begin
                    digit_d = dec_nib;
                    if (idx_inc == IW'(NUM_DIGITS)) begin
                        data_d       = word_shift;
                        data_valid_d = 1'b1;
                        word_d       = '0;
                        idx_d        = '0;
                    end else begin
                        word_d = word_shift;
                        idx_d  = idx_inc;
                    end
                end
                K_ILLEGAL: begin
                    error_d = 1'b1;
                    word_d  = '0;
                    idx_d   = '0;
                end
                default: ;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            ref_q        <= 7'b1111111;
            word_q       <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            digit_q      <= 4'h0;
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ref_q        <= ref_d;
            word_q       <= word_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            digit_q      <= digit_d;
            data_valid_q <= data_valid_d;
            error_q      <= error_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign digit      = digit_q;
    assign error      = error_q;
    assign busy       = (state_q != IDLE) || (idx_q != '0);

endmodule

// File: tb/tb_hex_decoder_capture.sv
// Bench for hex_decoder_capture: directed digit sequences, expected words and
// error pulses queued by the stimulus and checked by a monitor on output pulses.
module tb_hex_decoder_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:6]  HEX;
    logic        hex_valid;
    logic [15:0] data;
    logic        data_valid;
    logic [3:0]  digit;
    logic        error;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_err;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] ILL   = 7'b1110000;

    hex_decoder_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .HEX(HEX), .hex_valid(hex_valid),
        .data(data), .data_valid(data_valid), .digit(digit),
        .error(error), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Present a pattern for `hold` sampling edges, then release for one edge.
    task automatic send(input logic [6:0] pat, input int hold);
        @(negedge clk);
        HEX       = pat;
        hex_valid = 1'b1;
        repeat (hold) @(negedge clk);
        hex_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_word(input logic [15:0] w);
        exp_t e;
        e.is_err = 1'b0;
        e.val    = w;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input logic [15:0] held);
        exp_t e;
        e.is_err = 1'b1;
        e.val    = held;
        exp_q.push_back(e);
    endtask

    // Monitor: every data_valid / error pulse must match the next queued event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (data_valid || error) begin
                if (data_valid && error) begin
                    check("dv_and_err_exclusive", 1, 0);
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {data_valid, error}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(e.is_err ? "error_pulse" : "data_valid_pulse",
                          {30'd0, data_valid, error}, e.is_err ? 32'd1 : 32'd2);
                    check(e.is_err ? "data_held_on_error" : "data_word", data, e.val);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        hex_valid = 1'b1;
        HEX       = SEG[8];
        repeat (3) @(negedge clk);
        check("reset_data",  data, 0);
        check("reset_digit", digit, 0);
        check("reset_dv",    data_valid, 0);
        check("reset_err",   error, 0);
        check("reset_busy",  busy, 0);
        reset     = 1'b0;
        hex_valid = 1'b0;
        @(negedge clk);

        // 1,2,3,4 -> 1234
        push_word(16'h1234);
        send(SEG[1], 3); send(SEG[2], 3); send(SEG[3], 3); send(SEG[4], 3);
        check("digit_after_1234", digit, 4);
        check("busy_after_word",  busy, 0);

        // 3 held only 2 edges, then 5 held 3 -> only 5 accepted
        @(negedge clk);
        HEX = SEG[3]; hex_valid = 1'b1;
        repeat (2) @(negedge clk);
        HEX = SEG[5];
        repeat (3) @(negedge clk);
        hex_valid = 1'b0;
        @(negedge clk);
        check("digit_after_glitch", digit, 5);
        check("busy_partial_word",  busy, 1);
        check("data_held",          data, 16'h1234);

        // one more digit, then reset in the middle of settling the third
        send(SEG[6], 3);
        @(negedge clk);
        HEX = SEG[7]; hex_valid = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_data",  data, 0);
        check("midreset_digit", digit, 0);
        check("midreset_busy",  busy, 0);
        check("midreset_dv_err", {data_valid, error}, 0);
        reset = 1'b0; hex_valid = 1'b0;
        @(negedge clk);

        push_word(16'hCDEF);
        send(SEG[12], 3); send(SEG[13], 3); send(SEG[14], 3); send(SEG[15], 3);
        check("digit_after_cdef", digit, 4'hF);

        // A,B then illegal -> error, partial discarded; then 0001
        send(SEG[10], 3); send(SEG[11], 3);
        push_err(16'hCDEF);
        send(ILL, 3);
        check("busy_after_illegal",  busy, 0);
        check("digit_after_illegal", digit, 4'hB);
        push_word(16'h0001);
        send(SEG[0], 3); send(SEG[0], 3); send(SEG[0], 3); send(SEG[1], 3);

        // 7, blank, 8, 9, F -> 789F; blank leaves digit and index alone
        send(SEG[7], 3);
        send(BLANK, 3);
        check("digit_after_blank", digit, 7);
        check("busy_after_blank",  busy, 1);
        push_word(16'h789F);
        send(SEG[8], 3); send(SEG[9], 3); send(SEG[15], 3);
        check("digit_after_789f", digit, 4'hF);

        repeat (5) @(negedge clk);
        check("data_final_hold", data, 16'h789F);
        check("expected_events_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
